// File: rtl/rca_slice_sequencer.sv
// Multi-cycle adder: adds two N-bit operands through one SLICE_W-bit ripple-carry
// slice, least-significant slice first, with the inter-slice carry held in a register.
module rca_slice_sequencer #(
    parameter int SLICE_W = 4,
    parameter int SLICES  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [SLICE_W*SLICES-1:0]  a,
    input  logic [SLICE_W*SLICES-1:0]  b,
    input  logic                       cin,
    output logic                       busy,
    output logic                       done,
    output logic [SLICE_W*SLICES-1:0]  sum,
    output logic                       cout,
    output logic                       overflow
);

    localparam int N     = SLICE_W * SLICES;
    localparam int IDX_W = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   idx;
    logic [N-1:0]       a_q;
    logic [N-1:0]       b_q;
    logic               carry_q;
    logic [N-1:0]       sum_q;
    logic               cout_q;
    logic               overflow_q;

    logic               accept;
    logic               last_slice;
    int                 base;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               msb_carry_in;

    assign accept     = start && (state == IDLE || state == DONE);
    assign last_slice = (idx == IDX_W'(SLICES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: defaulting state_next before the case keeps this purely combinational
    // (an unassigned path would infer a latch).
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    state_next = start ? RUN : IDLE;
            RUN:     state_next = last_slice ? DONE : RUN;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // The shared slice adder; carry into the MSB is recovered from the sum bit.
    always_comb begin
        base                    = int'(idx) * SLICE_W;
        slice_a                 = a_q[base +: SLICE_W];
        slice_b                 = b_q[base +: SLICE_W];
        {slice_cout, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b}
                                  + {{SLICE_W{1'b0}}, carry_q};
        msb_carry_in            = slice_a[SLICE_W-1] ^ slice_b[SLICE_W-1]
                                  ^ slice_sum[SLICE_W-1];
    end

    // NOTE: operand and carry registers are reset too, so no X can reach the
    // adder even if RUN were entered without a prior capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else if (accept) begin
            idx     <= '0;
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
        end else if (state == RUN) begin
            sum_q[base +: SLICE_W] <= slice_sum;
            carry_q                <= slice_cout;
            if (last_slice) begin
                idx        <= '0;
                cout_q     <= slice_cout;
                overflow_q <= msb_carry_in ^ slice_cout;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_rca_slice_sequencer.sv
// Self-checking bench for rca_slice_sequencer: directed and random adds compared
// against an arithmetic reference model, plus ignored-start, streaming and reset cases.
module tb_rca_slice_sequencer;

    localparam int SLICE_W = 4;
    localparam int SLICES  = 4;
    localparam int N       = SLICE_W * SLICES;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         cout;
    logic         overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit overlap_seen = 1'b0;
    logic [N-1:0] prev_sum;

    rca_slice_sequencer #(.SLICE_W(SLICE_W), .SLICES(SLICES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .overflow (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (rst_n === 1'b1 && busy === 1'b1 && done === 1'b1) overlap_seen = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {overflow, cout, sum} of the full-width add.
    function automatic logic [N+1:0] ref_add(input logic [N-1:0] x, input logic [N-1:0] y,
                                             input logic c);
        logic [N:0] full;
        logic       ovf;
        full = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
        ovf  = (x[N-1] == y[N-1]) && (full[N-1] != x[N-1]);
        return {ovf, full};
    endfunction

    // Issue one add from an idle state; noise=1 pulses start with junk operands in RUN.
    task automatic run_op(input logic [N-1:0] op_a, input logic [N-1:0] op_b,
                          input logic op_cin, input bit noise, input string tag);
        logic [N+1:0] exp;
        int cycles;
        exp   = ref_add(op_a, op_b, op_cin);
        start = 1'b1; a = op_a; b = op_b; cin = op_cin;
        @(posedge clk); #1;
        start = 1'b0; a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        cycles = 0;
        while (done !== 1'b1 && cycles < 20) begin
            if (noise && cycles < 3) begin
                start = 1'b1; a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
            if (cycles == 1) begin
                check({tag, "_slice0"}, 32'(sum[SLICE_W-1:0]), 32'(exp[SLICE_W-1:0]));
                check({tag, "_upper_hold"}, 32'(sum[N-1:SLICE_W]), 32'(prev_sum[N-1:SLICE_W]));
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(cycles), 32'(SLICES));
        check({tag, "_sum"},  32'(sum),      32'(exp[N-1:0]));
        check({tag, "_cout"}, 32'(cout),     32'(exp[N]));
        check({tag, "_ovf"},  32'(overflow), 32'(exp[N+1]));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
        check({tag, "_sum_hold"}, 32'(sum), 32'(exp[N-1:0]));
        prev_sum = exp[N-1:0];
    endtask

    initial begin
        logic [N-1:0] sa [8];
        logic [N-1:0] sb [8];
        logic         sc [8];
        logic [N+1:0] exp;
        int           last_done;
        int           cycles;

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        prev_sum = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum",  32'(sum),  32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_ovf",  32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'h0000, 16'h0000, 1'b0, 1'b0, "zero");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "carry_all");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "pos_ovf");
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, "neg_ovf");
        run_op(16'h1234, 16'h4321, 1'b1, 1'b1, "ignore_start");

        for (int i = 0; i < 20; i++) begin
            run_op(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom), $sformatf("rand%0d", i));
        end

        // Streaming: start held high, new operands presented after each accept.
        for (int i = 0; i < 8; i++) begin
            sa[i] = N'($urandom); sb[i] = N'($urandom); sc[i] = 1'($urandom);
        end
        start = 1'b1; a = sa[0]; b = sb[0]; cin = sc[0];
        @(posedge clk); #1;
        a = sa[1]; b = sb[1]; cin = sc[1];
        last_done = -1;
        for (int k = 0; k < 6; k++) begin
            cycles = 0;
            while (done !== 1'b1 && cycles < 20) begin
                @(posedge clk); #1;
                cycles++;
            end
            exp = ref_add(sa[k], sb[k], sc[k]);
            check($sformatf("stream%0d_sum", k), 32'(sum), 32'(exp[N-1:0]));
            check($sformatf("stream%0d_cout", k), 32'(cout), 32'(exp[N]));
            check($sformatf("stream%0d_ovf", k), 32'(overflow), 32'(exp[N+1]));
            if (last_done >= 0)
                check($sformatf("stream%0d_period", k), 32'(cyc - last_done), 32'(SLICES + 1));
            last_done = cyc;
            @(posedge clk); #1;
            if (k < 5) begin
                a = sa[k + 2]; b = sb[k + 2]; cin = sc[k + 2];
            end else begin
                start = 1'b0;
            end
        end
        exp = ref_add(sa[5], sb[5], sc[5]);
        prev_sum = exp[N-1:0];
        while (busy === 1'b1 || done === 1'b1) begin
            @(posedge clk); #1;
        end

        // Reset in the second RUN cycle aborts asynchronously.
        start = 1'b1; a = 16'hABCD; b = 16'h1111; cin = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum",  32'(sum),  32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_ovf",  32'(overflow), 32'd0);
        @(posedge clk); #1;
        check("abort_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        prev_sum = '0;
        @(posedge clk); #1;
        run_op(16'hFFF0, 16'h0123, 1'b1, 1'b0, "after_reset");

        check("busy_done_overlap", 32'(overlap_seen), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rca_slice_sequencer.md
# rca_slice_sequencer

Multi-cycle adder controller. It adds two N-bit operands through a single SLICE_W-bit ripple-carry adder datapath, one slice per clock, least-significant slice first. The carry is registered between slices. Sits between a requester that issues start/operands and the shared ripple-carry adder, trading latency for a narrow carry chain. Reports sum, carry-out and signed overflow with a one-cycle done pulse.

## Interface

Parameters:
- SLICE_W, default 4: width of the ripple-carry adder slice (full-adder count); must be ≥ 2.
- SLICES, default 4: number of slices; must be ≥ 1. Total operand width N = SLICE_W*SLICES (16 by default).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronized externally.
- start  in  1  request. Sampled only while busy=0.
- a  in  N  operand A, captured on start acceptance.
- b  in  N  operand B, captured on start acceptance.
- cin  in  1  carry-in to slice 0, captured on start acceptance.
- busy  out  1  high while slices are being processed (RUN state).
- done  out  1  one-cycle pulse when the result is complete.
- sum  out  N  result register.
- cout  out  1  carry out of the MSB of the final slice.
- overflow  out  1  two's-complement overflow of the N-bit add.

## Operation

- States are IDLE, RUN and DONE.
- On reset: state=IDLE, slice index=0, busy=0, done=0, sum=0, cout=0, overflow=0, operand and carry registers are 0.
- IDLE, start=1: capture a, b, cin into internal registers; index=0; go to RUN. With start=0, stay in IDLE.
- RUN, each cycle:
  - Slice `idx` of the captured A and B, plus the carry register, feeds the SLICE_W-bit ripple-carry adder.
  - The slice sum is written to sum[idx*SLICE_W +: SLICE_W].
  - The carry register takes the slice carry-out, and idx increments.
- RUN, on the last slice (idx=SLICES-1):
  - cout takes the slice carry-out.
  - overflow takes (carry into the slice MSB) XOR (slice carry-out).
  - Go to DONE.
- DONE: done=1 for exactly this cycle.
  - start=1 is accepted exactly as in IDLE and goes straight to RUN.
  - Otherwise go to IDLE.
- start while busy=1 is ignored. The captured operands are unaffected and no queueing occurs.
- a, b and cin may change freely after the acceptance edge.
- sum bits of slices not yet processed keep their previous values during RUN.
- sum, cout and overflow are valid from the done cycle and hold until the next start acceptance completes its slices. The slices are overwritten progressively. cout and overflow change only on the last-slice edge.
- SLICES=1 degenerates to a single-cycle RUN: the accept edge is followed by one RUN cycle, then DONE.
- Reset asserted mid-operation aborts immediately: all outputs return to their reset values asynchronously, and no done pulse is produced.
- The arithmetic is modulo 2^N. cout is unsigned overflow; overflow is signed overflow.

## Timing

- Accept edge E0, where start=1 is sampled with busy=0: busy goes high after E0.
- Edges E1..E_SLICES each write one slice. E_SLICES also writes cout and overflow, and moves the state to DONE.
- After E_SLICES: busy=0 and done=1 for one cycle. Latency from the accept edge to done high is SLICES cycles (4 by default).
- Back-to-back issue (start held high or reasserted in the DONE cycle) gives one result every SLICES+1 cycles.
- busy and done are never high in the same cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- Reset, then 0x0000 + 0x0000, cin=0 -> done exactly 4 cycles after the accept edge; sum=0x0000, cout=0, overflow=0.
- 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, overflow=0. This exercises carry propagation across all slice boundaries.
- 0x7FFF + 0x0001 -> sum=0x8000, cout=0, overflow=1. Then 0x8000 + 0x8000 -> sum=0x0000, cout=1, overflow=1.
- 0x1234 + 0x4321, cin=1 -> sum=0x5556, cout=0, overflow=0. Also pulse start at cycles 1–3 of RUN with a different a and b -> ignored, and the result is unchanged.
- Hold start=1 continuously with a sequence of operand pairs -> one done pulse every 5 cycles, each with the correct sum; busy and done are never high together.
- Assert rst_n=0 in the second RUN cycle -> busy, done, sum, cout and overflow go to 0 immediately. After release, a new start completes normally with the correct result.
